// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default sizes for the video-memory A-port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// The command register in the arbiter is an arb_cmd_t, so the arbiter's DATA,
// ADDR and NREQ parameters are expected to match the defaults below; change
// them here when the port geometry changes.
package mem_arb_pkg;

  localparam int DEF_NREQ     = 4;   // requesters sharing the A-port
  localparam int DEF_DATA     = 8;   // memory data width
  localparam int DEF_ADDR     = 16;  // memory address width
  localparam int DEF_LOCK_MAX = 4;   // consecutive locked grants before rotation

  localparam int IDX_W = $clog2(DEF_NREQ);

  // Lock counter is wide enough for any LOCK_MAX up to 15.
  localparam int CNT_W = 4;

  // One memory command as it sits in the A-port register stage.
  typedef struct packed {
    logic [DEF_ADDR-1:0] addr;
    logic [DEF_DATA-1:0] wdata;
    logic                we;
    logic                re;
    logic [IDX_W-1:0]    src;   // requester that issued the command
  } arb_cmd_t;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Round-robin picker: first requesting index at or after the pointer, modulo NREQ.
// Latency: combinational.
// Backpressure: none; the caller gates the grant with its own enable.
//
// Ports: i_req  request vector
//        i_ptr  index where the search starts
//        o_gnt  one-hot winner (all zero when nobody requests)
//        o_idx  binary winner index (0 when nobody requests)
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IW-1:0]   o_idx
);

  logic [IW:0] w_pos;
  logic        w_found;

  // Walk NREQ positions starting at the pointer; the one extra bit in w_pos
  // absorbs the carry so the wrap can be done with a single subtract.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_pos   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_pos = {1'b0, i_ptr} + (IW+1)'(k);
      if (w_pos >= (IW+1)'(NREQ)) begin
        w_pos = w_pos - (IW+1)'(NREQ);
      end
      if (!w_found && i_req[w_pos[IW-1:0]]) begin
        w_found              = 1'b1;
        o_gnt[w_pos[IW-1:0]] = 1'b1;
        o_idx                = w_pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the video-memory A-port among NREQ requesters.
// Latency: command on the port 1 cycle after acceptance, read data 2 cycles after.
// Backpressure: valid/grant; a requester holds its request until gnt, one grant per cycle.
//
// Ports: clk/rst_L      A-port clock, asynchronous active-low reset
//        en             0 blocks new grants; in-flight commands still finish
//        req/lock/we    per-requester valid, priority retention, write select
//        addr/wdata     per-requester command payload
//        gnt            combinational one-hot acceptance
//        rvalid/rdata   one-hot read return and shared registered read data
//        mem_*          A-port command outputs and read data input
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ     = DEF_NREQ,
  parameter int DATA     = DEF_DATA,
  parameter int ADDR     = DEF_ADDR,
  parameter int LOCK_MAX = DEF_LOCK_MAX
) (
  input  logic                      clk,
  input  logic                      rst_L,
  input  logic                      en,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           lock,
  input  logic [NREQ-1:0]           we,
  input  logic [NREQ-1:0][ADDR-1:0] addr,
  input  logic [NREQ-1:0][DATA-1:0] wdata,
  output logic [NREQ-1:0]           gnt,
  output logic [NREQ-1:0]           rvalid,
  output logic [DATA-1:0]           rdata,
  output logic [ADDR-1:0]           mem_addr,
  output logic [DATA-1:0]           mem_wdata,
  output logic                      mem_we,
  output logic                      mem_re,
  input  logic [DATA-1:0]           mem_rdata
);

  localparam int IW = $clog2(NREQ);

  // Arbitration state
  logic [IW-1:0]    r_ptr;
  logic [CNT_W-1:0] r_cnt;

  // A-port command stage and read-return stage
  arb_cmd_t         r_cmd;
  logic [NREQ-1:0]  r_rvalid;
  logic [DATA-1:0]  r_rdata;

  logic [NREQ-1:0]  w_pick_gnt;
  logic [IW-1:0]    w_pick_idx;
  logic             w_acc;
  logic [CNT_W-1:0] w_cnt_eff;
  logic             w_keep;
  logic [IW-1:0]    w_ptr_inc;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx)
  );

  // Grant is held off during reset as well as when arbitration is disabled.
  assign gnt   = (en && rst_L) ? w_pick_gnt : '0;
  assign w_acc = |gnt;

  // The lock run only continues while the pointer's owner keeps requesting.
  // If it dropped req, the search starts past it, the winner is someone else,
  // and the run length restarts from zero.
  assign w_cnt_eff = req[r_ptr] ? r_cnt : '0;
  assign w_keep    = lock[w_pick_idx] && (w_cnt_eff < CNT_W'(LOCK_MAX - 1));
  assign w_ptr_inc = (w_pick_idx == IW'(NREQ - 1)) ? '0 : w_pick_idx + 1'b1;

  // Pointer / lock counter; frozen entirely while en=0.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (en) begin
      if (w_acc) begin
        if (w_keep) begin
          r_ptr <= w_pick_idx;
          r_cnt <= w_cnt_eff + 1'b1;
        end else begin
          r_ptr <= w_ptr_inc;
          r_cnt <= '0;
        end
      end else begin
        r_cnt <= w_cnt_eff;
      end
    end
  end

  // Command stage: address/data hold across idle cycles, strobes drop.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      r_cmd <= '0;
    end else if (w_acc) begin
      r_cmd.addr  <= addr[w_pick_idx];
      r_cmd.wdata <= wdata[w_pick_idx];
      r_cmd.we    <= we[w_pick_idx];
      r_cmd.re    <= ~we[w_pick_idx];
      r_cmd.src   <= w_pick_idx;
    end else begin
      r_cmd.we <= 1'b0;
      r_cmd.re <= 1'b0;
    end
  end

  // Read return: mem_rdata is only meaningful while a read is on the port,
  // so it is captured then and rdata holds otherwise.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      r_rvalid <= '0;
      r_rdata  <= '0;
    end else if (r_cmd.re) begin
      r_rvalid <= NREQ'(1) << r_cmd.src;
      r_rdata  <= mem_rdata;
    end else begin
      r_rvalid <= '0;
    end
  end

  assign mem_addr  = r_cmd.addr;
  assign mem_wdata = r_cmd.wdata;
  assign mem_we    = r_cmd.we;
  assign mem_re    = r_cmd.re;
  assign rvalid    = r_rvalid;
  assign rdata     = r_rdata;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Round-robin arbiter that shares the single 4 MHz read/write port (A-port) of the dual-port video memory among NREQ requesters, such as the z80 bus interface and a DMA/loader engine.
- Each requester uses a valid/grant handshake. The block issues at most one memory command per cycle and routes registered read data back to the requester that issued the read.
- An optional lock lets a requester run short bursts (for example, block transfers), capped at LOCK_MAX consecutive grants.

Parameters:
NREQ, 4, number of requesters (2..8)
DATA, 8, memory data width
ADDR, 16, memory address width
LOCK_MAX, 4, maximum consecutive locked grants to one requester before forced rotation (1..15)

Ports:
clk  in  1  memory A-port clock
rst_L  in  1  reset
en  in  1  arbitration enable; 0 = no new grants
req  in  NREQ  request valid, one per requester
lock  in  NREQ  request priority retention for the next cycle
we  in  NREQ  1 = write, 0 = read
addr  in  NREQ x ADDR  request address
wdata  in  NREQ x DATA  write data
gnt  out  NREQ  one-hot acceptance (combinational)
rvalid  out  NREQ  one-hot read-data-valid
rdata  out  DATA  read data, shared by all requesters
mem_addr  out  ADDR  to memory a_addr
mem_wdata  out  DATA  to memory data_in
mem_we  out  1  to memory a_we
mem_re  out  1  to memory a_re
mem_rdata  in  DATA  from memory a_data_out

Behaviour:
- Reset: rst_L is asynchronous, active-low; clock is clk. While rst_L=0:
  - gnt forced to 0.
  - mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0.
  - rvalid=0, rdata=0.
  - Priority pointer=0, lock counter=0, read-pending pipeline cleared.
- Handshake:
  - A request is accepted in cycle t when req[i]=1 and gnt[i]=1.
  - The requester holds req/we/addr/wdata stable until accepted.
  - gnt is 0 whenever en=0.
  - gnt never asserts without req.
- Winner selection: the first requesting index at or after the pointer, searching modulo NREQ.
- Pipeline:
  - Cycle t: acceptance.
  - End of t: mem_addr, mem_wdata, mem_we, mem_re are registered from the winner. During t+1 they drive the memory.
  - The memory samples at the end of t+1.
  - For a read: rvalid[winner]=1 in t+2, and rdata = mem_rdata registered.
  - Read latency is 2 cycles from acceptance. Writes produce no rvalid.
- Idle cycles (no acceptance): mem_we=0 and mem_re=0 in the following cycle. mem_addr and mem_wdata hold their last values.
- rdata holds its value when rvalid=0. mem_rdata is ignored except in the capture cycle, because the memory drives Z when not reading.
- Pointer and lock update on each acceptance by requester i:
  - If lock[i]=1 and count < LOCK_MAX-1: pointer stays at i, count++.
  - Otherwise: pointer = (i+1) mod NREQ, count = 0.
  - If the locked requester drops req, the next winner is chosen normally and count resets to 0.
- Throughput: back-to-back acceptances every cycle. A read's rvalid can coincide with a later acceptance or command in the same cycle; this is required.
- Read after write to the same address, accepted in consecutive cycles, returns the new data.
- en=0 mid-stream: in-flight commands and rvalid still complete. Pointer and count are frozen.
- Reset mid-operation: in-flight reads are dropped. No rvalid appears after reset deassertion for commands accepted before reset.

Decomposition:
- Package mem_arb_pkg holds:
  - Defaults NREQ, DATA, ADDR, LOCK_MAX.
  - Index width localparam $clog2(NREQ).
  - typedef arb_cmd_t with fields addr, wdata, we, re, src index.
- Sub-module rr_pick: combinational round-robin picker. Inputs are the req vector and pointer; outputs are a one-hot grant and a binary index.
- Pipeline registers, pointer, and lock counter live in the top module.

Test Plan:
1. Reset with req=4'b1111 and en=1 -> gnt=0, mem_we=mem_re=0, rvalid=0. After release with req=4'b0001, gnt=4'b0001 in the first cycle.
2. req[1] read, addr=0x1234, with memory preloaded 0xA5 -> gnt[1] in t; mem_re=1 and mem_addr=0x1234 in t+1; rvalid=4'b0010 and rdata=0xA5 in t+2.
3. req=4'b1111 held continuously, lock=0 -> grant order 0,1,2,3,0,1, one per cycle, with no idle command cycles.
4. req=4'b1111, lock[2]=1, LOCK_MAX=4, pointer at 2 -> grants 2,2,2,2,3,0. Then with lock[2] still 1, grant 2 four times again.
5. req[0] write 0x5A to 0x0010 then read 0x0010 in consecutive cycles -> mem_we in t+1, mem_re in t+2, rvalid[0] with rdata=0x5A in t+3.
6. req[3] read accepted in t, rst_L pulsed low in t+1 -> rvalid stays 0 through t+5, and the pointer is 0 after reset.
